matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control sequencer for the DIM×DIM matrix-multiply datapath (C = A·B). On a `start` request it walks the i/j/k loop nest and issues read addresses for matrices A and B. It drives the MAC clear/enable strobes and issues one write of each C element. It replaces the per-matrix free-running address state machines with a single coordinated scheduler and reports completion through a `busy`/`done` handshake.

## Interface
- `DIM`, default 3, matrix dimension (1..32).
- `AW`, default max(1, $clog2(DIM*DIM)), flat element-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: global enable; low freezes the sequencer.
- `start` in 1: run request; sampled only in IDLE with `ena`=1.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse when the run is complete.
- `rd_en` out 1: read strobe for the A and B memories.
- `addr_a` out AW: i*DIM+k.
- `addr_b` out AW: k*DIM+j.
- `mac_clr` out 1: accumulator loads the product instead of adding it; coincident with `mac_en` for k=0.
- `mac_en` out 1: accumulator update; `rd_en` delayed one enabled cycle.
- `wr_en` out 1: write strobe for the C memory.
- `addr_c` out AW: i*DIM+j; valid while `wr_en`=1.

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: `start`=1 → RUN, with i=j=k=0.
- RUN: `rd_en`=1 and addresses come from the current (i,j,k).
  - k<DIM-1: k++.
  - k=DIM-1: k←0, go to DRAIN.
- DRAIN: `mac_en`=1 for the last k; no read.
- WRITE: `wr_en`=1 and `addr_c` = i*DIM+j.
  - Advance j; on j wrap, advance i.
  - If (i,j) was (DIM-1,DIM-1) → DONE, else → RUN.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored. This includes the DONE cycle; no queueing.
- `ena`=0: state, counters and the mac pipeline register all hold. `rd_en`, `mac_en`, `mac_clr`, `wr_en` and `done` are forced 0. On `ena`=1 the sequence resumes exactly where it stopped.
- Datapath requirement: the memory read-data register holds its value while `rd_en`=0.
- Address arithmetic is unsigned and truncated to AW. No overflow is possible because the maximum address is DIM*DIM-1.
- DIM=1: RUN lasts 1 cycle per element; the k counter is a constant 0.

## Timing
- All outputs are registered. Reset values: all outputs 0, state IDLE, i=j=k=0.
- `rst` takes effect at the next edge in any state, aborting a run with no `done`. The first cycle after reset is IDLE with all strobes 0.
- Let `start` be sampled at edge 0 (ena held high):
  - RUN begins cycle 1.
  - Each C element takes DIM+2 cycles: DIM RUN, 1 DRAIN, 1 WRITE.
  - Element e is written in cycle (DIM+2)(e+1).
  - `done` is in cycle DIM*DIM*(DIM+2)+1; IDLE in the next cycle.
  - DIM=3: element 0 written in cycle 5, last write in cycle 45, `done` in cycle 46.
- `mac_en`/`mac_clr` lag `rd_en` by exactly one enabled cycle. Stall cycles do not count.

## Structure
- Shared package `matmul_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/WRITE/DONE);
  - a `clog2_min1` function, used for AW and the counter widths;
  - the constant `MAX_DIM`=32.
- One sub-module, `wrap_counter`, is instantiated three times (k, j, i).
  - Parameter MAX.
  - Inputs: `clk`, `rst`, `clr`, `inc`.
  - Outputs: `q` and `last` (q==MAX-1).
  - Carry chaining is done in the sequencer.
- Address multiply-adds (i*DIM+k, k*DIM+j, i*DIM+j) are computed from counter values in combinational logic and registered at the outputs.

## Test plan
- DIM=3, pulse `start` once.
  - Exactly 27 `rd_en` and 9 `wr_en`.
  - `addr_c` sequence 0..8.
  - `done` in cycle 46; `busy` high in cycles 1..46.
- DIM=3, first element.
  - `addr_a`/`addr_b` pairs (0,0),(1,3),(2,6).
  - `mac_clr` only with the first `mac_en`.
  - `wr_en` with `addr_c`=0 in cycle 5.
- `start` held high for the whole run.
  - Exactly one run, one `done`.
  - A new run starts from IDLE on the following sample.
- `ena` low for 4 cycles during element 4's RUN.
  - Address and strobe sequence is identical apart from the gap.
  - `done` is delayed by exactly 4 cycles (cycle 50).
- `rst` asserted in cycle 20.
  - Next cycle: IDLE, all outputs 0, no `done`.
  - A following `start` produces a full, correct run.
- DIM=1.
  - `start` → `rd_en` cycle 1 (addr 0,0), `mac_en`+`mac_clr` cycle 2, `wr_en` cycle 3 with `addr_c`=0, `done` cycle 4.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: state encoding, width helper and limits shared by the matmul sequencer
package matmul_pkg;

    localparam int MAX_DIM = 32;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_sequencer_wrap_counter.sv
// wrap_counter: modulo-MAX loop index with synchronous clear and terminal-count flag
module wrap_counter
    import matmul_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = clog2_min1(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         last
);

    assign last = (q == W'(MAX - 1));

    always_ff @(posedge clk) begin
        q <= (rst || clr) ? '0 : inc ? (last ? '0 : q + W'(1)) : q;
    end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks the i/j/k loop nest of C = A*B, issuing A/B reads,
// MAC clear/enable strobes and one C write per element, all from registers.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DIM = 3,
    parameter int AW  = clog2_min1(DIM * DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          wr_en,
    output logic [AW-1:0] addr_c
);

    localparam int CW = clog2_min1(DIM);

    state_e        state_q, state_d;
    logic [CW-1:0] i_q, j_q, k_q;
    logic [CW-1:0] i_d, j_d, k_d;
    logic          i_last, j_last, k_last;
    logic          go, k_inc, j_inc, i_inc;
    logic          busy_q, done_q, rd_en_q, mac_clr_q, mac_en_q, wr_en_q;
    logic [AW-1:0] addr_a_q, addr_b_q, addr_c_q;

    function automatic logic [CW-1:0] step(input logic [CW-1:0] q, input logic clr,
                                           input logic inc, input logic last);
        return clr ? '0 : inc ? (last ? '0 : q + CW'(1)) : q;
    endfunction

    function automatic logic [AW-1:0] mad(input logic [CW-1:0] hi, input logic [CW-1:0] lo);
        return AW'(hi) * AW'(DIM) + AW'(lo);
    endfunction

    assign go    = ena && state_q == S_IDLE && start;
    assign k_inc = ena && state_q == S_RUN;
    assign j_inc = ena && state_q == S_WRITE;
    assign i_inc = j_inc && j_last;

    wrap_counter #(.MAX(DIM)) u_k (.clk(clk), .rst(rst), .clr(go), .inc(k_inc), .q(k_q), .last(k_last));
    wrap_counter #(.MAX(DIM)) u_j (.clk(clk), .rst(rst), .clr(go), .inc(j_inc), .q(j_q), .last(j_last));
    wrap_counter #(.MAX(DIM)) u_i (.clk(clk), .rst(rst), .clr(go), .inc(i_inc), .q(i_q), .last(i_last));

    // Outputs are registered from next-cycle indices so they line up with the state entered
    assign k_d = step(k_q, go, k_inc, k_last);
    assign j_d = step(j_q, go, j_inc, j_last);
    assign i_d = step(i_q, go, i_inc, i_last);

    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                S_IDLE:  state_d = start ? S_RUN : S_IDLE;
                S_RUN:   state_d = k_last ? S_DRAIN : S_RUN;
                S_DRAIN: state_d = S_WRITE;
                S_WRITE: state_d = (i_last && j_last) ? S_DONE : S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The held state_q/k_q act as the MAC pipeline stage across stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
        end else if (!ena) begin
            {done_q, rd_en_q, mac_en_q, mac_clr_q, wr_en_q} <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= state_d != S_IDLE;
            done_q    <= state_d == S_DONE;
            rd_en_q   <= state_d == S_RUN;
            wr_en_q   <= state_d == S_WRITE;
            mac_en_q  <= state_q == S_RUN;
            mac_clr_q <= state_q == S_RUN && k_q == '0;
            addr_a_q  <= mad(i_d, k_d);
            addr_b_q  <= mad(k_d, j_d);
            addr_c_q  <= mad(i_d, j_d);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign mac_en  = mac_en_q;
    assign mac_clr = mac_clr_q;
    assign wr_en   = wr_en_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign addr_c  = addr_c_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench for DIM=3 (normal, stall, held start, reset abort) and DIM=1
module tb_matmul_sequencer;

    localparam int D = 3;

    logic       clk = 1'b0, rst = 1'b1;
    logic       ena3 = 1'b0, start3 = 1'b0, ena1 = 1'b0, start1 = 1'b0;
    logic       busy3, done3, rd3, mclr3, men3, wr3;
    logic [3:0] aa3, ab3, ac3;
    logic       busy1, done1, rd1, mclr1, men1, wr1;
    logic [0:0] aa1, ab1, ac1;
    int         checks = 0, errors = 0;

    typedef struct {int a; int b; int k; int c;} rd_t;
    typedef struct {int addr; int c;} wr_t;
    rd_t rdq[$];
    wr_t wrq[$];

    always #5 clk = ~clk;

    matmul_sequencer #(.DIM(D)) u3 (
        .clk(clk), .rst(rst), .ena(ena3), .start(start3), .busy(busy3), .done(done3),
        .rd_en(rd3), .addr_a(aa3), .addr_b(ab3), .mac_clr(mclr3), .mac_en(men3),
        .wr_en(wr3), .addr_c(ac3)
    );

    matmul_sequencer #(.DIM(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena1), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd1), .addr_a(aa1), .addr_b(ab1), .mac_clr(mclr1), .mac_en(men1),
        .wr_en(wr1), .addr_c(ac1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int adj(input int x, input int sa, input int sl);
        return (sl > 0 && x > sa) ? x + sl : x;
    endfunction

    task automatic run3(input int sa, input int sl, input bit hold, input int abort_at);
        int  exp_done, nrd, nwr, ndone, pend, pclr, pcyc;
        bit  aborted;
        rd_t r;
        wr_t w;
        rdq.delete();
        wrq.delete();
        for (int e = 0; e < D * D; e++) begin
            for (int k = 0; k < D; k++)
                rdq.push_back('{(e / D) * D + k, k * D + (e % D), k, (D + 2) * e + 1 + k});
            wrq.push_back('{e, (D + 2) * (e + 1)});
        end
        exp_done = adj(D * D * (D + 2) + 1, sa, sl);
        nrd = 0; nwr = 0; ndone = 0; pend = 0; pclr = 0; pcyc = 0; aborted = 1'b0;
        start3 = 1'b1;
        for (int n = 1; n <= exp_done + 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) start3 = 1'b0;
            if (n <= exp_done + 1) begin
                check("busy", busy3, n <= exp_done);
                if (men3) begin
                    check("mac_pend", pend, 1);
                    check("mac_clr", mclr3, pclr);
                    check("mac_cyc", n, pcyc);
                    pend = 0;
                end else check("clr_alone", mclr3, 0);
                if (rd3) begin
                    check("rd_avail", rdq.size() > 0, 1);
                    if (rdq.size() > 0) begin
                        r = rdq.pop_front();
                        check("addr_a", aa3, r.a);
                        check("addr_b", ab3, r.b);
                        check("rd_cyc", n, adj(r.c, sa, sl));
                        nrd++;
                        pend = 1;
                        pclr = (r.k == 0);
                        pcyc = adj(r.c + 1, sa, sl);
                    end
                end
                if (wr3) begin
                    check("wr_avail", wrq.size() > 0, 1);
                    if (wrq.size() > 0) begin
                        w = wrq.pop_front();
                        check("addr_c", ac3, w.addr);
                        check("wr_cyc", n, adj(w.c, sa, sl));
                        nwr++;
                    end
                end
                if (done3) begin
                    check("done_cyc", n, exp_done);
                    ndone++;
                end
            end else if (hold) begin
                check("restart_rd", rd3, 1);
                check("restart_busy", busy3, 1);
            end else begin
                check("stay_idle", busy3 | rd3, 0);
            end
            if (sl > 0 && n == sa) ena3 = 1'b0;
            if (sl > 0 && n == sa + sl) ena3 = 1'b1;
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("abort_outs", {busy3, done3, rd3, men3, mclr3, wr3, aa3, ab3, ac3}, 0);
                check("abort_done", ndone, 0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check("rd_count", nrd, D * D * D);
            check("wr_count", nwr, D * D);
            check("done_count", ndone, 1);
            check("rd_left", rdq.size(), 0);
            check("wr_left", wrq.size(), 0);
        end
        if (hold) begin
            start3 = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            check("hold_rst_busy", busy3, 0);
        end
    endtask

    task automatic run1();
        start1 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            check("d1_rd", rd1, n == 1);
            check("d1_mac", men1, n == 2);
            check("d1_clr", mclr1, n == 2);
            check("d1_wr", wr1, n == 3);
            check("d1_done", done1, n == 4);
            check("d1_busy", busy1, n <= 4);
            if (n == 1) check("d1_addr_ab", {aa1, ab1}, 0);
            if (n == 3) check("d1_addr_c", ac1, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_u3", {busy3, done3, rd3, men3, mclr3, wr3, aa3, ab3, ac3}, 0);
        check("rst_u1", {busy1, done1, rd1, men1, mclr1, wr1, aa1, ab1, ac1}, 0);
        rst  = 1'b0;
        ena3 = 1'b1;
        ena1 = 1'b1;
        @(negedge clk);
        run3(0, 0, 1'b0, 0);
        run3(21, 4, 1'b0, 0);
        run3(0, 0, 1'b1, 0);
        run3(0, 0, 1'b0, 20);
        run3(0, 0, 1'b0, 0);
        run1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
